// File: rtl/dac_serial_tx.sv
// dac_serial_tx: serialises filtered samples onto the 3-wire DAC bus
// (clk_DAC / DAC_Din / DAC_Sync). Each frame is CTRL_WORD then the sample, MSB first.
// clk_DAC is a register-generated strobe in the clk_100MHz domain, not a clock net.
// Build option: define OFFSET_BINARY_EN to convert two's-complement samples to
// offset binary at capture (MSB inverted). Timing is identical in both builds.
module dac_serial_tx #(
  parameter int                DATA_W    = 12,
  parameter int                CTRL_W    = 4,
  parameter logic [CTRL_W-1:0] CTRL_WORD = 4'h0,
  parameter int                CLK_DIV   = 2,
  parameter int                SYNC_GAP  = 4
) (
  input  logic              clk_100MHz,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              clk_DAC,
  output logic              DAC_Din,
  output logic              DAC_Sync,
  output logic              frame_done
);

  localparam int FRAME_W = CTRL_W + DATA_W;
  localparam int DIV_CW  = (CLK_DIV  > 1) ? $clog2(CLK_DIV)  : 1;
  localparam int BIT_CW  = (FRAME_W  > 1) ? $clog2(FRAME_W)  : 1;
  localparam int GAP_CW  = (SYNC_GAP > 1) ? $clog2(SYNC_GAP) : 1;

  localparam logic [DIV_CW-1:0] DIV_LAST = DIV_CW'(CLK_DIV - 1);
  localparam logic [BIT_CW-1:0] BIT_LAST = BIT_CW'(FRAME_W - 1);
  localparam logic [GAP_CW-1:0] GAP_LAST = GAP_CW'(SYNC_GAP - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    GAP   = 2'd3
  } state_t;

  state_t              state, state_nxt;
  logic [DIV_CW-1:0]   div_cnt, div_nxt;
  logic                half, half_nxt;     // 0: clk_DAC low half of a bit, 1: high half
  logic [BIT_CW-1:0]   bit_cnt, bit_nxt;
  logic [GAP_CW-1:0]   gap_cnt, gap_nxt;
  logic [FRAME_W-1:0]  shreg, shreg_nxt;
  logic                ready_nxt, clk_dac_nxt, din_bit_nxt, sync_nxt, done_nxt;

  // Map the filter's two's-complement sample onto the DAC input code.
  function automatic logic [DATA_W-1:0] to_dac_code(input logic signed [DATA_W-1:0] s);
`ifdef OFFSET_BINARY_EN
    return $unsigned(s) ^ {1'b1, {(DATA_W-1){1'b0}}};
`else
    return $unsigned(s);
`endif
  endfunction

  // Next-state, counter and shift-register logic; outputs are derived from the
  // next state so that every bus pin comes straight out of a flop.
  always_comb begin
    state_nxt   = state;
    div_nxt     = div_cnt;
    half_nxt    = half;
    bit_nxt     = bit_cnt;
    gap_nxt     = gap_cnt;
    shreg_nxt   = shreg;
    unique case (state)
      IDLE: begin
        // din_ready is high exactly in IDLE, so valid alone marks a transfer
        if (din_valid) begin
          state_nxt = SETUP;
          div_nxt   = '0;
          shreg_nxt = {CTRL_WORD, to_dac_code(din)};
        end
      end
      SETUP: begin
        if (div_cnt == DIV_LAST) begin
          state_nxt = SHIFT;
          div_nxt   = '0;
          half_nxt  = 1'b0;
          bit_nxt   = '0;
        end else begin
          div_nxt = div_cnt + 1'b1;
        end
      end
      SHIFT: begin
        if (div_cnt == DIV_LAST) begin
          div_nxt = '0;
          if (!half) begin
            // rising clk_DAC: present the next bit, keeping the last one steady
            half_nxt = 1'b1;
            if (bit_cnt != BIT_LAST)
              shreg_nxt = {shreg[FRAME_W-2:0], 1'b0};
          end else if (bit_cnt == BIT_LAST) begin
            state_nxt = GAP;
            gap_nxt   = '0;
          end else begin
            half_nxt = 1'b0;
            bit_nxt  = bit_cnt + 1'b1;
          end
        end else begin
          div_nxt = div_cnt + 1'b1;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST)
          state_nxt = IDLE;
        else
          gap_nxt = gap_cnt + 1'b1;
      end
      default: state_nxt = IDLE;
    endcase

    ready_nxt   = (state_nxt == IDLE);
    clk_dac_nxt = 1'b1;
    sync_nxt    = 1'b1;
    din_bit_nxt = 1'b0;
    done_nxt    = (state == SHIFT) && (state_nxt == GAP);
    case (state_nxt)
      SETUP: begin
        sync_nxt    = 1'b0;
        din_bit_nxt = shreg_nxt[FRAME_W-1];
      end
      SHIFT: begin
        sync_nxt    = 1'b0;
        clk_dac_nxt = half_nxt;
        din_bit_nxt = shreg_nxt[FRAME_W-1];
      end
      default: ;
    endcase
  end

  // Control state, counters and registered bus outputs; reset abandons any frame.
  always_ff @(posedge clk_100MHz or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      div_cnt    <= '0;
      half       <= 1'b0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      din_ready  <= 1'b1;
      clk_DAC    <= 1'b1;
      DAC_Din    <= 1'b0;
      DAC_Sync   <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      div_cnt    <= div_nxt;
      half       <= half_nxt;
      bit_cnt    <= bit_nxt;
      gap_cnt    <= gap_nxt;
      din_ready  <= ready_nxt;
      clk_DAC    <= clk_dac_nxt;
      DAC_Din    <= din_bit_nxt;
      DAC_Sync   <= sync_nxt;
      frame_done <= done_nxt;
    end
  end

  // Frame shift register holds data only, so it carries no reset.
  always_ff @(posedge clk_100MHz) begin
    shreg <= shreg_nxt;
  end

endmodule
